// File: rtl/debug_spi_master_pkg.sv
// Shared definitions for the debug SPI master: FSM encoding, slave targets and defaults.
package debug_spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int NB_CS = 4;

  localparam logic [1:0] TGT_FETCH  = 2'd0;
  localparam logic [1:0] TGT_DECODE = 2'd1;
  localparam logic [1:0] TGT_EXEC   = 2'd2;
  localparam logic [1:0] TGT_MEM    = 2'd3;

  localparam int CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/debug_spi_master_shift_reg.sv
// SPI shift register: parallel-load MSB-first TX shifter plus serial-in RX shifter.
module debug_spi_master_shift_reg #(
  parameter int NB_BITS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               load,
  input  logic [NB_BITS-1:0] load_data,
  input  logic               shift_tx,
  input  logic               shift_rx,
  input  logic               rx_bit,
  output logic               tx_msb,
  output logic [NB_BITS-1:0] rx_word
);

  logic [NB_BITS-1:0] tx_q;
  logic [NB_BITS-1:0] rx_q;

  // NOTE: both shifters are plain registers, not RAM, so resetting them costs nothing and keeps MOSI defined.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load)
        tx_q <= load_data;
      else if (shift_tx)
        tx_q <= {tx_q[NB_BITS-2:0], 1'b0};
      if (shift_rx)
        rx_q <= {rx_q[NB_BITS-2:0], rx_bit};
    end
  end

  assign tx_msb  = tx_q[NB_BITS-1];
  assign rx_word = rx_q;

endmodule

// File: rtl/debug_spi_master.sv
// Debug SPI master (mode 0): one full-duplex NB_BITS transfer per command to one pipeline-stage slave.
module debug_spi_master
  import debug_spi_master_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_CS   = debug_spi_master_pkg::NB_CS,
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int NB_DIV  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_target,
  input  logic [NB_BITS-1:0] i_tx_data,
  input  logic               i_MISO,
  output logic               o_SCLK,
  output logic               o_MOSI,
  output logic [NB_CS-1:0]   o_SPI_cs,
  output logic [NB_BITS-1:0] o_rx_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BCNT = $clog2(NB_BITS);

  state_e              state, next_state;
  logic [NB_DIV-1:0]   div_cnt;
  logic [NB_BCNT-1:0]  bit_cnt;
  logic [NB_CS-1:0]    cs_q;
  logic                sclk_q;
  logic                done_q;
  logic [NB_BITS-1:0]  rx_data_q;
  logic                tick;
  logic                load;
  logic                shift;
  logic                tx_msb;
  logic [NB_BITS-1:0]  rx_word;

  assign tick = (div_cnt == '0);

  // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE:  if (i_start) begin
                  next_state = ST_SETUP;
                  load       = 1'b1;
                end
      ST_SETUP: if (tick) next_state = ST_HIGH;
      ST_HIGH:  if (tick) begin
                  next_state = ST_LOW;
                  shift      = 1'b1;
                end
      ST_LOW:   if (tick) next_state = (bit_cnt == '0) ? ST_HOLD : ST_HIGH;
      ST_HOLD:  if (tick) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt   <= NB_DIV'(CLK_DIV - 1);
      bit_cnt   <= '0;
      cs_q      <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      if (next_state != state)
        div_cnt <= NB_DIV'(CLK_DIV - 1);
      else if (!tick)
        div_cnt <= div_cnt - 1'b1;

      if (load)
        bit_cnt <= NB_BCNT'(NB_BITS - 1);
      else if (state == ST_LOW && tick && bit_cnt != '0)
        bit_cnt <= bit_cnt - 1'b1;

      if (load)
        cs_q <= NB_CS'(1) << i_target;
      else if (state == ST_HOLD && tick)
        cs_q <= '0;

      // Registered so SCLK is a clean flop output rather than a state decode.
      sclk_q <= (next_state == ST_HIGH);
      done_q <= (state == ST_HOLD && tick);

      if (state == ST_HOLD && tick)
        rx_data_q <= rx_word;
    end
  end

  // TX shifts and MISO is captured on the same edge: the last HIGH cycle ends as LOW begins.
  debug_spi_master_shift_reg #(.NB_BITS(NB_BITS)) u_shift_reg (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (load),
    .load_data (i_tx_data),
    .shift_tx  (shift),
    .shift_rx  (shift),
    .rx_bit    (i_MISO),
    .tx_msb    (tx_msb),
    .rx_word   (rx_word)
  );

  assign o_SCLK    = sclk_q;
  assign o_MOSI    = (state != ST_IDLE) && tx_msb;
  assign o_SPI_cs  = cs_q;
  assign o_rx_data = rx_data_q;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = done_q;

endmodule

// File: tb/tb_debug_spi_master.sv
// Scoreboard bench for debug_spi_master: slave model, reference queue and a CLK_DIV=6 instance.
module tb_debug_spi_master;
  import debug_spi_master_pkg::*;

  localparam int NB_BITS = 32;
  localparam int CLK_DIV = 4;
  localparam int LAT     = (2 * NB_BITS + 2) * CLK_DIV;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [1:0]         target;
  logic [NB_BITS-1:0] tx_data;
  logic               miso;
  logic               sclk, mosi, busy, done;
  logic [NB_CS-1:0]   cs;
  logic [NB_BITS-1:0] rx_data;

  logic               start6;
  logic [NB_BITS-1:0] tx6;
  logic               sclk6, mosi6, busy6, done6;
  logic [NB_CS-1:0]   cs6;
  logic [NB_BITS-1:0] rx6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debug_spi_master #(.NB_BITS(NB_BITS), .NB_CS(NB_CS), .CLK_DIV(CLK_DIV), .NB_DIV(8)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_target(target), .i_tx_data(tx_data),
    .i_MISO(miso), .o_SCLK(sclk), .o_MOSI(mosi), .o_SPI_cs(cs), .o_rx_data(rx_data),
    .o_busy(busy), .o_done(done)
  );

  debug_spi_master #(.NB_BITS(NB_BITS), .NB_CS(NB_CS), .CLK_DIV(6), .NB_DIV(8)) u_dut6 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start6), .i_target(TGT_DECODE), .i_tx_data(tx6),
    .i_MISO(1'b0), .o_SCLK(sclk6), .o_MOSI(mosi6), .o_SPI_cs(cs6), .o_rx_data(rx6),
    .o_busy(busy6), .o_done(done6)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
  endtask

  // Reference model: a command accepted at edge E completes LAT edges later and the
  // returned word is whatever the addressed slave (or the loopback wire) shifted back.
  typedef struct {
    logic [NB_BITS-1:0] rx;
    logic [NB_BITS-1:0] tx;
    logic [1:0]         tgt;
    longint             done_edge;
  } exp_t;

  exp_t               exp_q[$];
  longint             edge_n    = 0;
  longint             free_edge = 0;
  logic [NB_BITS-1:0] slave_word [NB_CS];
  logic               loop_mode = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      free_edge = 0;
    end else begin
      edge_n++;
      if (start && edge_n >= free_edge) begin
        exp_q.push_back('{rx: loop_mode ? tx_data : slave_word[target], tx: tx_data,
                          tgt: target, done_edge: edge_n + LAT});
        free_edge = edge_n + LAT + 1;
      end
    end
  end

  // Loopback wire: MOSI delayed by one system clock.
  logic mosi_d = 1'b0;
  always @(posedge clk) mosi_d <= mosi;

  // Mode-0 slave: presents its MSB when selected, captures MOSI on SCLK rise, shifts on fall.
  logic [NB_BITS-1:0] sreg = '0;
  logic [NB_BITS-1:0] srx  = '0;
  int                 rises = 0;
  logic [NB_CS-1:0]   cs_or = '0;
  logic [NB_CS-1:0]   prev_cs = '0;
  logic               cs_bad = 1'b0;
  logic               prev_sclk = 1'b0;
  logic               prev_done = 1'b0;

  assign miso = loop_mode ? mosi_d : sreg[NB_BITS-1];

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_one_pulse", prev_done, 1'b0);
      check("done_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.rx);
        check("done_latency", edge_n, e.done_edge);
        check("slave_got_mosi", srx, e.tx);
        check("sclk_rises", rises, NB_BITS);
        check("cs_onehot", cs_or, NB_CS'(1) << e.tgt);
        check("cs_stable_sclk_high", cs_bad, 1'b0);
      end
    end
    prev_done = done;

    if (cs != '0 && prev_cs == '0) begin
      for (int i = NB_CS - 1; i >= 0; i--)
        if (cs[i]) sreg = slave_word[i];
      rises  = 0;
      cs_or  = '0;
      cs_bad = 1'b0;
    end
    cs_or = cs_or | cs;
    if (cs != prev_cs && (sclk || prev_sclk)) cs_bad = 1'b1;
    if (sclk && !prev_sclk) begin
      srx = {srx[NB_BITS-2:0], mosi};
      rises++;
    end
    if (!sclk && prev_sclk) sreg = {sreg[NB_BITS-2:0], 1'b0};
    prev_sclk = sclk;
    prev_cs   = cs;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    check("done_timeout", done, 1'b1);
  endtask

  task automatic xfer(input logic [1:0] t, input logic [NB_BITS-1:0] d, input logic lp);
    wait_idle();
    loop_mode = lp;
    target    = t;
    tx_data   = d;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, runlen, hi_len, lo_len;
    logic prev_s;

    rst_n = 1'b0; start = 1'b0; target = '0; tx_data = '0; start6 = 1'b0; tx6 = '0;
    for (int i = 0; i < NB_CS; i++) slave_word[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_outputs", {sclk, mosi, cs, busy, done, rx_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {sclk, mosi, cs, busy, done, rx_data}, '0);

    // Directed transfers: exec target pattern, loopback, fetch slave word.
    xfer(TGT_EXEC, 32'hA5A5_0F0F, 1'b0);
    xfer(TGT_FETCH, 32'hDEAD_BEEF, 1'b1);
    slave_word[0] = 32'h1234_5678;
    xfer(TGT_FETCH, $urandom, 1'b0);
    @(negedge clk);
    check("mosi_idle_low", mosi, 1'b0);

    // Start held high: the second command is taken on the edge ending the done cycle.
    wait_idle();
    loop_mode = 1'b0; target = TGT_MEM; tx_data = $urandom; start = 1'b1;
    @(negedge clk);
    wait_done();
    @(negedge clk);
    check("busy_after_back_to_back", busy, 1'b1);
    start = 1'b0;
    wait_done();

    // Asynchronous reset around bit 10 of a transfer.
    wait_idle();
    target = TGT_DECODE; tx_data = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rises < 10 && n < 2000) begin @(negedge clk); n++; end
    check("reached_bit10", rises >= 10, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", {sclk, mosi, cs, busy, done, rx_data}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 20) @(negedge clk);
    check("abort_rx_zero", rx_data, '0);
    xfer(TGT_EXEC, $urandom, 1'b0);

    // Randomised commands with fresh slave words.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NB_CS; i++) slave_word[i] = $urandom;
      xfer(2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
    end

    // CLK_DIV=6 instance: phase lengths and latency. Done shows on the negedge of the
    // cycle after edge T+(2*NB_BITS+2)*6, i.e. the (396+1)-th negedge after edge T.
    tx6 = $urandom;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    n = 1; runlen = 1; hi_len = 0; lo_len = 0; prev_s = sclk6;
    while (!done6 && n < 2000) begin
      @(negedge clk);
      n++;
      if (sclk6 == prev_s) runlen++;
      else begin
        if (prev_s && hi_len == 0) hi_len = runlen;
        else if (!prev_s && hi_len != 0 && lo_len == 0) lo_len = runlen;
        runlen = 1;
      end
      prev_s = sclk6;
    end
    check("div6_latency", n, (2 * NB_BITS + 2) * 6 + 1);
    check("div6_high_phase", hi_len, 6);
    check("div6_low_phase", lo_len, 6);
    check("div6_rx", rx6, '0);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_spi_master.md
Name: debug_spi_master

Overview:
- SPI master that drives the pipeline's debug SPI port (MOSI, SCLK, one-hot chip select) and captures MISO.
- One command performs one NB_BITS-wide full-duplex transfer with one selected stage slave: fetch, decode, execute or memory.
- Sits between the debug command source (micro/UART bridge) and the MIPS core.
- Returns the word shifted out by the slave; the transferred word reaches the stage's from-SPI register.

Parameters:
- NB_BITS, 32, transfer word width (matches core data width).
- NB_CS, 4, number of chip selects / stage slaves.
- CLK_DIV, 4, system clocks per SCLK half-period; legal minimum is 4, to cover the slave's SCLK synchronizer.
- NB_DIV, 8, width of the half-period counter; must satisfy CLK_DIV < 2^NB_DIV.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  transfer request; sampled only in IDLE.
- i_target  in  2  slave index: 0 fetch, 1 decode, 2 exec, 3 mem.
- i_tx_data  in  NB_BITS  word to send, MSB first.
- i_MISO  in  1  serial data from the selected slave.
- o_SCLK  out  1  SPI clock; idles low (mode 0).
- o_MOSI  out  1  serial data to the slaves.
- o_SPI_cs  out  NB_CS  one-hot chip select, active-high.
- o_rx_data  out  NB_BITS  last received word.
- o_busy  out  1  high from the cycle after start is accepted until return to IDLE.
- o_done  out  1  one-cycle pulse when o_rx_data is updated.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE; o_SCLK=0, o_MOSI=0, o_SPI_cs=0, o_busy=0, o_done=0, o_rx_data=0.
  - The aborted transfer produces no o_done.
- States: IDLE -> SETUP -> (HIGH -> LOW) x NB_BITS -> HOLD -> IDLE.
  - A down-counter loaded with CLK_DIV-1 times every state; the state advances when the counter reaches 0.
- IDLE:
  - i_start=1 latches i_tx_data into the TX shift register and i_target into the cs register, then moves to SETUP.
  - i_start while not in IDLE is ignored; there is no queueing.
- SETUP (CLK_DIV cycles):
  - o_SPI_cs[target]=1, other cs bits 0.
  - o_MOSI=tx[NB_BITS-1]; o_SCLK=0; bit counter = NB_BITS-1.
- HIGH (CLK_DIV cycles):
  - o_SCLK=1.
  - On the last cycle of HIGH, i_MISO is shifted into the RX register LSB (late sampling tolerates slave latency).
- LOW (CLK_DIV cycles):
  - o_SCLK=0.
  - On entry the TX register shifts left and o_MOSI presents the next bit.
  - When the bit counter is 0, go to HOLD; otherwise decrement the counter and go to HIGH.
- HOLD (CLK_DIV cycles):
  - SCLK stays 0 and cs stays asserted.
  - On exit, cs drops to 0, o_rx_data<=RX register, o_done=1 for one cycle, state=IDLE.
- Latency:
  - Start sampled at edge T; o_done is high in the cycle after edge T+(2*NB_BITS+2)*CLK_DIV.
  - Default: 264 cycles.
  - o_busy is low in the same cycle o_done is high, so back-to-back starts are accepted in the o_done cycle.
- o_MOSI returns to 0 in IDLE. o_rx_data holds its value between transfers.
- cs is never asserted for more than one target, and never changes while SCLK=1.

Decomposition:
- Shared debug package holds:
  - state encoding (IDLE/SETUP/HIGH/LOW/HOLD, 3 bits);
  - NB_CS;
  - the target index constants TGT_FETCH=0, TGT_DECODE=1, TGT_EXEC=2, TGT_MEM=3;
  - the default CLK_DIV.
- One sub-module is natural: spi_shift_reg, a parallel-load, MSB-first TX/RX shifter with load, shift_tx and shift_rx enables.

Test Plan:
- Reset with i_rst=0 mid-idle, then release:
  - all outputs 0.
  - i_start with target=2, tx=0xA5A5_0F0F: o_SPI_cs=4'b0100 and MOSI bits equal 1010... MSB first on 32 rising SCLK edges.
  - o_done at cycle 264.
- Loopback: i_MISO tied to o_MOSI delayed 1 cycle, tx=0xDEAD_BEEF -> o_rx_data=0xDEAD_BEEF on o_done, one pulse only.
- Slave model returning 0x1234_5678 with target=0:
  - o_rx_data=0x1234_5678;
  - exactly 32 SCLK rising edges while cs[0]=1; cs[3:1] stay 0.
- i_start held high across a transfer:
  - second start ignored until the o_done cycle;
  - next transfer begins on that edge, o_busy back to 1 next cycle.
- i_rst asserted at bit 10 of a transfer:
  - o_SCLK, o_SPI_cs, o_busy go 0 immediately (asynchronous).
  - No o_done; o_rx_data=0.
  - A new transfer after release completes normally.
- CLK_DIV=6 build: SCLK high/low phases are 6 cycles each; o_done at cycle (64+2)*6=396.
